pong_ball_engine: RTL and testbench



---
 rtl/pong_pkg.sv | 37 +++
 rtl/pong_ball_collide.sv | 111 +++++++++++
 rtl/pong_ball_engine.sv | 188 ++++++++++++++++++
 tb/tb_pong_ball_engine.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared geometry defaults, FSM states and direction encoding for the Pong ball engine.
package pong_pkg;

    localparam int unsigned XW = 10;
    localparam int unsigned SW = 4;

    localparam int unsigned DEF_SCREEN_W    = 640;
    localparam int unsigned DEF_SCREEN_H    = 480;
    localparam int unsigned DEF_BALL_SIZE   = 8;
    localparam int unsigned DEF_PADDLE_W    = 15;
    localparam int unsigned DEF_PADDLE_H    = 80;
    localparam int unsigned DEF_P1_X        = 10;
    localparam int unsigned DEF_P2_X        = 615;
    localparam int unsigned DEF_SPEED_X     = 4;
    localparam int unsigned DEF_SPEED_Y     = 3;
    localparam int unsigned DEF_SERVE_DELAY = 60;
    localparam int unsigned DEF_SCORE_MAX   = 9;

    typedef enum logic [2:0] {
        IDLE,
        SERVE_WAIT,
        PLAY,
        POINT,
        GAME_OVER
    } state_t;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

    // Score increment that sticks at the all-ones value.
    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] s);
        return (s == {SW{1'b1}}) ? s : s + SW'(1);
    endfunction

endpackage

// File: rtl/pong_ball_collide.sv
// One-tick ball motion: wall bounces, paddle hits and miss detection (combinational).
// miss_p1 means the left player missed, miss_p2 means the right player missed.
module pong_ball_collide
    import pong_pkg::*;
#(
    parameter int unsigned SCREEN_W  = DEF_SCREEN_W,
    parameter int unsigned SCREEN_H  = DEF_SCREEN_H,
    parameter int unsigned BALL_SIZE = DEF_BALL_SIZE,
    parameter int unsigned PADDLE_W  = DEF_PADDLE_W,
    parameter int unsigned PADDLE_H  = DEF_PADDLE_H,
    parameter int unsigned P1_X      = DEF_P1_X,
    parameter int unsigned P2_X      = DEF_P2_X,
    parameter int unsigned SPEED_X   = DEF_SPEED_X,
    parameter int unsigned SPEED_Y   = DEF_SPEED_Y
) (
    input  logic [XW-1:0] x,
    input  logic [XW-1:0] y,
    input  dir_t          dx,
    input  dir_t          dy,
    input  logic [XW-1:0] p1_y,
    input  logic [XW-1:0] p2_y,
    output logic [XW-1:0] nx,
    output logic [XW-1:0] ny,
    output dir_t          ndx,
    output dir_t          ndy,
    output logic          miss_p1,
    output logic          miss_p2
);

    localparam int unsigned AW = XW + 1;

    localparam logic [AW-1:0] C_SW  = AW'(SCREEN_W);
    localparam logic [AW-1:0] C_SH  = AW'(SCREEN_H);
    localparam logic [AW-1:0] C_BS  = AW'(BALL_SIZE);
    localparam logic [AW-1:0] C_PH  = AW'(PADDLE_H);
    localparam logic [AW-1:0] C_P1R = AW'(P1_X + PADDLE_W);
    localparam logic [AW-1:0] C_P2X = AW'(P2_X);
    localparam logic [AW-1:0] C_SX  = AW'(SPEED_X);
    localparam logic [AW-1:0] C_SY  = AW'(SPEED_Y);

    logic [AW-1:0] x11;
    logic [AW-1:0] y11;
    logic [AW-1:0] p1_11;
    logic [AW-1:0] p2_11;
    logic          overlap_p1;
    logic          overlap_p2;
    logic          hit_left;
    logic          hit_right;
    logic          out_left;
    logic          out_right;

    assign x11   = {1'b0, x};
    assign y11   = {1'b0, y};
    assign p1_11 = {1'b0, p1_y};
    assign p2_11 = {1'b0, p2_y};

    assign overlap_p1 = (y11 + C_BS > p1_11) && (y11 < p1_11 + C_PH);
    assign overlap_p2 = (y11 + C_BS > p2_11) && (y11 < p2_11 + C_PH);

    // Crossing tests written as additions so nothing can wrap below zero.
    assign hit_left  = (dx == DIR_NEG) && (x11 >= C_P1R) && (x11 < C_P1R + C_SX) && overlap_p1;
    assign hit_right = (dx == DIR_POS) && (x11 + C_BS <= C_P2X) && (x11 + C_BS + C_SX > C_P2X)
                       && overlap_p2;
    assign out_left  = (dx == DIR_NEG) && (x11 < C_SX);
    assign out_right = (dx == DIR_POS) && (x11 + C_BS + C_SX > C_SW);

    // Vertical and horizontal motion resolved independently; a miss freezes the ball.
    always_comb begin
        nx      = x;
        ny      = y;
        ndx     = dx;
        ndy     = dy;
        miss_p1 = 1'b0;
        miss_p2 = 1'b0;

        if (dy == DIR_NEG) begin
            if (y11 < C_SY) begin
                ny  = '0;
                ndy = DIR_POS;
            end else begin
                ny = XW'(y11 - C_SY);
            end
        end else begin
            if (y11 + C_BS + C_SY > C_SH) begin
                ny  = XW'(C_SH - C_BS);
                ndy = DIR_NEG;
            end else begin
                ny = XW'(y11 + C_SY);
            end
        end

        if (hit_left) begin
            nx  = XW'(C_P1R);
            ndx = DIR_POS;
        end else if (hit_right) begin
            nx  = XW'(C_P2X - C_BS);
            ndx = DIR_NEG;
        end else if (out_left || out_right) begin
            miss_p1 = out_left;
            miss_p2 = out_right;
            nx      = x;
            ny      = y;
            ndy     = dy;
        end else if (dx == DIR_NEG) begin
            nx = XW'(x11 - C_SX);
        end else begin
            nx = XW'(x11 + C_SX);
        end
    end

endmodule

// File: rtl/pong_ball_engine.sv
// Pong ball owner: serve/play/point/game-over sequencing, scores and ball registers.
module pong_ball_engine
    import pong_pkg::*;
#(
    parameter int unsigned SCREEN_W    = DEF_SCREEN_W,
    parameter int unsigned SCREEN_H    = DEF_SCREEN_H,
    parameter int unsigned BALL_SIZE   = DEF_BALL_SIZE,
    parameter int unsigned PADDLE_W    = DEF_PADDLE_W,
    parameter int unsigned PADDLE_H    = DEF_PADDLE_H,
    parameter int unsigned P1_X        = DEF_P1_X,
    parameter int unsigned P2_X        = DEF_P2_X,
    parameter int unsigned SPEED_X     = DEF_SPEED_X,
    parameter int unsigned SPEED_Y     = DEF_SPEED_Y,
    parameter int unsigned SERVE_DELAY = DEF_SERVE_DELAY,
    parameter int unsigned SCORE_MAX   = DEF_SCORE_MAX
) (
    input  logic          i_CLK,
    input  logic          i_RST_n,
    input  logic          i_tick,
    input  logic          i_serve,
    input  logic [XW-1:0] i_p1_y,
    input  logic [XW-1:0] i_p2_y,
    output logic [XW-1:0] o_ball_x,
    output logic [XW-1:0] o_ball_y,
    output logic [SW-1:0] o_p1_score,
    output logic [SW-1:0] o_p2_score,
    output logic          o_point,
    output logic          o_game_over
);

    localparam int unsigned   CNT_W    = $clog2(SERVE_DELAY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DELAY - 1);
    localparam logic [XW-1:0] CENTRE_X = XW'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [XW-1:0] CENTRE_Y = XW'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [SW-1:0] SMAX     = SW'(SCORE_MAX);

    state_t           state,    nxt_state;
    logic [XW-1:0]    ball_x,   nxt_x;
    logic [XW-1:0]    ball_y,   nxt_y;
    dir_t             dx,       nxt_dx;
    dir_t             dy,       nxt_dy;
    logic [CNT_W-1:0] cnt,      nxt_cnt;
    logic [SW-1:0]    p1_score, nxt_p1;
    logic [SW-1:0]    p2_score, nxt_p2;
    logic             point,    nxt_point;
    logic             game_over, nxt_go;

    logic [XW-1:0] col_x;
    logic [XW-1:0] col_y;
    dir_t          col_dx;
    dir_t          col_dy;
    logic          miss_p1;
    logic          miss_p2;

    pong_ball_collide #(
        .SCREEN_W  (SCREEN_W),
        .SCREEN_H  (SCREEN_H),
        .BALL_SIZE (BALL_SIZE),
        .PADDLE_W  (PADDLE_W),
        .PADDLE_H  (PADDLE_H),
        .P1_X      (P1_X),
        .P2_X      (P2_X),
        .SPEED_X   (SPEED_X),
        .SPEED_Y   (SPEED_Y)
    ) u_collide (
        .x       (ball_x),
        .y       (ball_y),
        .dx      (dx),
        .dy      (dy),
        .p1_y    (i_p1_y),
        .p2_y    (i_p2_y),
        .nx      (col_x),
        .ny      (col_y),
        .ndx     (col_dx),
        .ndy     (col_dy),
        .miss_p1 (miss_p1),
        .miss_p2 (miss_p2)
    );

    // State and datapath registers; everything returns to the centred idle ball on reset.
    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state     <= IDLE;
            ball_x    <= CENTRE_X;
            ball_y    <= CENTRE_Y;
            dx        <= DIR_POS;
            dy        <= DIR_POS;
            cnt       <= '0;
            p1_score  <= '0;
            p2_score  <= '0;
            point     <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state     <= nxt_state;
            ball_x    <= nxt_x;
            ball_y    <= nxt_y;
            dx        <= nxt_dx;
            dy        <= nxt_dy;
            cnt       <= nxt_cnt;
            p1_score  <= nxt_p1;
            p2_score  <= nxt_p2;
            point     <= nxt_point;
            game_over <= nxt_go;
        end
    end

    // Next-state logic; scoring and recentring happen on entry to POINT so they show with o_point.
    always_comb begin
        nxt_state = state;
        nxt_x     = ball_x;
        nxt_y     = ball_y;
        nxt_dx    = dx;
        nxt_dy    = dy;
        nxt_cnt   = cnt;
        nxt_p1    = p1_score;
        nxt_p2    = p2_score;
        nxt_point = 1'b0;

        unique case (state)
            IDLE: begin
                if (i_serve) begin
                    nxt_state = SERVE_WAIT;
                end
            end
            SERVE_WAIT: begin
                if (i_tick) begin
                    if (cnt == CNT_LAST) begin
                        nxt_state = PLAY;
                        nxt_cnt   = '0;
                    end else begin
                        nxt_cnt = cnt + CNT_W'(1);
                    end
                end
            end
            PLAY: begin
                if (i_tick) begin
                    if (miss_p1 || miss_p2) begin
                        nxt_state = POINT;
                        nxt_point = 1'b1;
                        nxt_x     = CENTRE_X;
                        nxt_y     = CENTRE_Y;
                        nxt_dy    = DIR_POS;
                        if (miss_p1) begin
                            nxt_p2 = sat_inc(p2_score);
                            nxt_dx = DIR_NEG;
                        end else begin
                            nxt_p1 = sat_inc(p1_score);
                            nxt_dx = DIR_POS;
                        end
                    end else begin
                        nxt_x  = col_x;
                        nxt_y  = col_y;
                        nxt_dx = col_dx;
                        nxt_dy = col_dy;
                    end
                end
            end
            POINT: begin
                if ((p1_score == SMAX) || (p2_score == SMAX)) begin
                    nxt_state = GAME_OVER;
                end else begin
                    nxt_state = SERVE_WAIT;
                end
            end
            GAME_OVER: begin
                if (i_serve) begin
                    nxt_state = SERVE_WAIT;
                    nxt_p1    = '0;
                    nxt_p2    = '0;
                    nxt_dx    = DIR_POS;
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase

        nxt_go = (nxt_state == GAME_OVER);
    end

    assign o_ball_x    = ball_x;
    assign o_ball_y    = ball_y;
    assign o_p1_score  = p1_score;
    assign o_p2_score  = p2_score;
    assign o_point     = point;
    assign o_game_over = game_over;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Directed bench: collision vector table plus serve, point, game-over and reset sequences.
module tb_pong_ball_engine;
    import pong_pkg::*;

    logic          clk;
    logic          rst_n;
    logic          tick;
    logic          serve;
    logic [9:0]    p1_y;
    logic [9:0]    p2_y;
    logic [9:0]    ball_x;
    logic [9:0]    ball_y;
    logic [3:0]    p1_score;
    logic [3:0]    p2_score;
    logic          point;
    logic          game_over;

    logic [9:0] c_x, c_y, c_p1, c_p2, c_nx, c_ny;
    dir_t       c_dx, c_dy, c_ndx, c_ndy;
    logic       c_m1, c_m2;

    int n_cmp;
    int n_bad;

    pong_ball_engine #(
        .SERVE_DELAY (2),
        .SCORE_MAX   (2)
    ) dut (
        .i_CLK       (clk),
        .i_RST_n     (rst_n),
        .i_tick      (tick),
        .i_serve     (serve),
        .i_p1_y      (p1_y),
        .i_p2_y      (p2_y),
        .o_ball_x    (ball_x),
        .o_ball_y    (ball_y),
        .o_p1_score  (p1_score),
        .o_p2_score  (p2_score),
        .o_point     (point),
        .o_game_over (game_over)
    );

    pong_ball_collide u_col (
        .x       (c_x),
        .y       (c_y),
        .dx      (c_dx),
        .dy      (c_dy),
        .p1_y    (c_p1),
        .p2_y    (c_p2),
        .nx      (c_nx),
        .ny      (c_ny),
        .ndx     (c_ndx),
        .ndy     (c_ndy),
        .miss_p1 (c_m1),
        .miss_p2 (c_m2)
    );

    typedef struct {
        logic [9:0] x, y;
        dir_t       dx, dy;
        logic [9:0] p1, p2;
        logic [9:0] ex, ey;
        dir_t       edx, edy;
        logic       em1, em2;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic chk_ball(input string name, input int ex, input int ey);
        n_cmp++;
        if (int'(ball_x) != ex || int'(ball_y) != ey) begin
            n_bad++;
            $display("FAIL %s: got ball %0d/%0d, want %0d/%0d", name, ball_x, ball_y, ex, ey);
        end
    endtask

    task automatic do_tick();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic pulse_serve();
        @(negedge clk) serve = 1'b1;
        @(negedge clk) serve = 1'b0;
    endtask

    // Serve, wait out the two-tick delay, then take the first play tick.
    task automatic serve_and_first(input string tag);
        pulse_serve();
        do_ticks(2);
        chk_ball({tag, "_serve_wait"}, 316, 236);
        do_tick();
        chk_ball({tag, "_first_tick"}, 320, 239);
    endtask

    // Tick until a point is flagged; report how many ticks it took (0 if never).
    task automatic run_to_point(output int n);
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            do_tick();
            if (point) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        tick  = 1'b0;
        serve = 1'b0;
        p1_y  = 10'd0;
        p2_y  = 10'd0;

        // x, y, dx, dy, p1, p2 -> x, y, dx, dy, miss_p1, miss_p2
        vecs[0]  = '{10'd605, 10'd230, DIR_POS, DIR_POS, 10'd0,   10'd200, 10'd607, 10'd233, DIR_NEG, DIR_POS, 1'b0, 1'b0};
        vecs[1]  = '{10'd605, 10'd230, DIR_POS, DIR_POS, 10'd0,   10'd300, 10'd609, 10'd233, DIR_POS, DIR_POS, 1'b0, 1'b0};
        vecs[2]  = '{10'd300, 10'd2,   DIR_POS, DIR_NEG, 10'd0,   10'd0,   10'd304, 10'd0,   DIR_POS, DIR_POS, 1'b0, 1'b0};
        vecs[3]  = '{10'd300, 10'd3,   DIR_POS, DIR_NEG, 10'd0,   10'd0,   10'd304, 10'd0,   DIR_POS, DIR_NEG, 1'b0, 1'b0};
        vecs[4]  = '{10'd300, 10'd469, DIR_POS, DIR_POS, 10'd0,   10'd0,   10'd304, 10'd472, DIR_POS, DIR_POS, 1'b0, 1'b0};
        vecs[5]  = '{10'd300, 10'd470, DIR_POS, DIR_POS, 10'd0,   10'd0,   10'd304, 10'd472, DIR_POS, DIR_NEG, 1'b0, 1'b0};
        vecs[6]  = '{10'd605, 10'd2,   DIR_POS, DIR_NEG, 10'd0,   10'd0,   10'd607, 10'd0,   DIR_NEG, DIR_POS, 1'b0, 1'b0};
        vecs[7]  = '{10'd27,  10'd100, DIR_NEG, DIR_POS, 10'd50,  10'd0,   10'd25,  10'd103, DIR_POS, DIR_POS, 1'b0, 1'b0};
        vecs[8]  = '{10'd29,  10'd100, DIR_NEG, DIR_POS, 10'd50,  10'd0,   10'd25,  10'd103, DIR_NEG, DIR_POS, 1'b0, 1'b0};
        vecs[9]  = '{10'd25,  10'd100, DIR_NEG, DIR_POS, 10'd50,  10'd0,   10'd25,  10'd103, DIR_POS, DIR_POS, 1'b0, 1'b0};
        vecs[10] = '{10'd27,  10'd100, DIR_NEG, DIR_POS, 10'd300, 10'd0,   10'd23,  10'd103, DIR_NEG, DIR_POS, 1'b0, 1'b0};
        vecs[11] = '{10'd3,   10'd100, DIR_NEG, DIR_POS, 10'd300, 10'd0,   10'd3,   10'd100, DIR_NEG, DIR_POS, 1'b1, 1'b0};
        vecs[12] = '{10'd4,   10'd100, DIR_NEG, DIR_POS, 10'd300, 10'd0,   10'd0,   10'd103, DIR_NEG, DIR_POS, 1'b0, 1'b0};
        vecs[13] = '{10'd629, 10'd100, DIR_POS, DIR_POS, 10'd0,   10'd300, 10'd629, 10'd100, DIR_POS, DIR_POS, 1'b0, 1'b1};
        vecs[14] = '{10'd628, 10'd100, DIR_POS, DIR_POS, 10'd0,   10'd300, 10'd632, 10'd103, DIR_POS, DIR_POS, 1'b0, 1'b0};
        vecs[15] = '{10'd604, 10'd192, DIR_POS, DIR_POS, 10'd0,   10'd200, 10'd608, 10'd195, DIR_POS, DIR_POS, 1'b0, 1'b0};
        vecs[16] = '{10'd604, 10'd279, DIR_POS, DIR_POS, 10'd0,   10'd200, 10'd607, 10'd282, DIR_NEG, DIR_POS, 1'b0, 1'b0};
        vecs[17] = '{10'd604, 10'd280, DIR_POS, DIR_POS, 10'd0,   10'd200, 10'd608, 10'd283, DIR_POS, DIR_POS, 1'b0, 1'b0};

        for (int i = 0; i < NV; i++) begin
            c_x  = vecs[i].x;
            c_y  = vecs[i].y;
            c_dx = vecs[i].dx;
            c_dy = vecs[i].dy;
            c_p1 = vecs[i].p1;
            c_p2 = vecs[i].p2;
            #1;
            n_cmp++;
            if (c_nx !== vecs[i].ex || c_ny !== vecs[i].ey || c_ndx !== vecs[i].edx ||
                c_ndy !== vecs[i].edy || c_m1 !== vecs[i].em1 || c_m2 !== vecs[i].em2) begin
                n_bad++;
                $display("FAIL collide[%0d]: got x=%0d y=%0d dx=%0d dy=%0d m1=%0d m2=%0d, want x=%0d y=%0d dx=%0d dy=%0d m1=%0d m2=%0d",
                         i, c_nx, c_ny, c_ndx, c_ndy, c_m1, c_m2, vecs[i].ex, vecs[i].ey,
                         vecs[i].edx, vecs[i].edy, vecs[i].em1, vecs[i].em2);
            end
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk_ball("reset_ball", 316, 236);
        chk("reset_p1_score", int'(p1_score), 0);
        chk("reset_p2_score", int'(p2_score), 0);
        chk("reset_point", int'(point), 0);
        chk("reset_game_over", int'(game_over), 0);
        @(negedge clk) rst_n = 1'b1;

        // Idle ball ignores ticks
        do_ticks(100);
        chk_ball("idle_no_move", 316, 236);

        // First rally: right player (p2_y=0) misses after 80 play ticks
        serve_and_first("g1");
        run_to_point(n);
        chk("g1_ticks_to_point", n, 79);
        chk("g1_p1_score", int'(p1_score), 1);
        chk("g1_p2_score", int'(p2_score), 0);
        chk_ball("g1_point_recentre", 316, 236);
        @(negedge clk);
        chk("g1_point_pulse_len", int'(point), 0);
        chk("g1_no_game_over", int'(game_over), 0);

        // Serve ignored while waiting; ball relaunches to the right, then reset mid-play
        serve_and_first("g2");
        do_ticks(4);
        chk_ball("g2_play_5_ticks", 336, 251);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_ball("midplay_reset_ball", 316, 236);
        chk("midplay_reset_p1", int'(p1_score), 0);
        chk("midplay_reset_go", int'(game_over), 0);
        @(negedge clk) rst_n = 1'b1;
        do_ticks(100);
        chk_ball("after_reset_idle", 316, 236);

        // Two P1 points end the game
        serve_and_first("g3");
        run_to_point(n);
        chk("g3_ticks_to_point", n, 79);
        chk("g3_p1_score", int'(p1_score), 1);
        @(negedge clk);
        serve_and_first("g4");
        run_to_point(n);
        chk("g4_ticks_to_point", n, 79);
        chk("g4_p1_score", int'(p1_score), 2);
        chk("g4_go_during_point", int'(game_over), 0);
        @(negedge clk);
        chk("g4_game_over", int'(game_over), 1);
        chk("g4_point_cleared", int'(point), 0);
        chk_ball("g4_game_over_ball", 316, 236);
        do_ticks(20);
        chk_ball("game_over_frozen", 316, 236);
        chk("game_over_held", int'(game_over), 1);

        // Restart from game over
        pulse_serve();
        chk("restart_p1_score", int'(p1_score), 0);
        chk("restart_p2_score", int'(p2_score), 0);
        chk("restart_game_over", int'(game_over), 0);
        do_ticks(2);
        chk_ball("restart_serve_wait", 316, 236);
        do_tick();
        chk_ball("restart_first_tick", 320, 239);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
